irrigation_input_conditioner: RTL and testbench



---
 rtl/irrigation_input_conditioner.sv | 209 ++++++++++++++++++++
 tb/tb_irrigation_input_conditioner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_input_conditioner.sv
// Switch front-end for the irrigation controller: 2-FF sync, per-channel debounce FSM, edge pulses, conflict flag.
// Optional long-press detection is enabled by defining IRRIGATION_HOLD_DETECT_EN.
//
//   state       | meaning
//   LOW_STABLE  | debounced level is 0, synced input agrees
//   PEND_HIGH   | synced input is 1, counting toward a rising qualification
//   HIGH_STABLE | debounced level is 1, synced input agrees
//   PEND_LOW    | synced input is 0, counting toward a falling qualification
module irrigation_input_conditioner #(
   parameter int CHANNELS        = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5,
   parameter int HOLD_CYCLES     = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] stable_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic                conflict,
   output logic                busy,
   output logic [CHANNELS-1:0] hold
);

   typedef enum logic [1:0] {
      LOW_STABLE  = 2'd0,
      PEND_HIGH   = 2'd1,
      HIGH_STABLE = 2'd2,
      PEND_LOW    = 2'd3
   } db_state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CHANNELS-1:0] meta_q, meta_d;
   logic [CHANNELS-1:0] sync_q, sync_d;
   logic [CHANNELS-1:0] stable_q, stable_d;
   logic [CHANNELS-1:0] rise_q, rise_d;
   logic [CHANNELS-1:0] fall_q, fall_d;
   logic                busy_q, busy_d;
   logic [CHANNELS-1:0] pend_d;

   db_state_e        state_q [CHANNELS];
   db_state_e        state_d [CHANNELS];
   logic [CNT_W-1:0] cnt_q   [CHANNELS];
   logic [CNT_W-1:0] cnt_d   [CHANNELS];

   always_comb begin
      meta_d = raw_in;
      sync_d = meta_q;
   end

   always_comb begin
      stable_d = stable_q;
      rise_d   = '0;
      fall_d   = '0;
      pend_d   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            LOW_STABLE: begin
               if (sync_q[i]) begin
                  state_d[i] = PEND_HIGH;
                  cnt_d[i]   = '0;
               end
            end
            PEND_HIGH: begin
               if (!sync_q[i]) begin
                  state_d[i] = LOW_STABLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i]  = HIGH_STABLE;
                  cnt_d[i]    = '0;
                  stable_d[i] = 1'b1;
                  rise_d[i]   = 1'b1;
               end else if (cnt_q[i] < CNT_LAST) begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            HIGH_STABLE: begin
               if (!sync_q[i]) begin
                  state_d[i] = PEND_LOW;
                  cnt_d[i]   = '0;
               end
            end
            PEND_LOW: begin
               if (sync_q[i]) begin
                  state_d[i] = HIGH_STABLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i]  = LOW_STABLE;
                  cnt_d[i]    = '0;
                  stable_d[i] = 1'b0;
                  fall_d[i]   = 1'b1;
               end else if (cnt_q[i] < CNT_LAST) begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            default: begin
               state_d[i] = LOW_STABLE;
               cnt_d[i]   = '0;
            end
         endcase
         pend_d[i] = (state_d[i] == PEND_HIGH) || (state_d[i] == PEND_LOW);
      end
      busy_d = |pend_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta_q   <= '0;
         sync_q   <= '0;
         stable_q <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         busy_q   <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= LOW_STABLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         meta_q   <= meta_d;
         sync_q   <= sync_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         busy_q   <= busy_d;
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign stable_out = stable_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = busy_q;

   // Sprinkler (bit 0) and drip (bit 1) together is the only conflicting pair.
   generate
      if (CHANNELS >= 2) begin : g_conflict
         logic conflict_q, conflict_d;

         always_comb begin
            conflict_d = conflict_q;
            if (stable_q[0] && stable_q[1]) begin
               conflict_d = 1'b1;
            end else if (!stable_q[0] && !stable_q[1]) begin
               conflict_d = 1'b0;
            end
         end

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               conflict_q <= 1'b0;
            end else begin
               conflict_q <= conflict_d;
            end
         end

         assign conflict = conflict_q;
      end else begin : g_no_conflict
         assign conflict = 1'b0;
      end
   endgenerate

`ifdef IRRIGATION_HOLD_DETECT_EN
   localparam int               HOLD_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

   logic [HOLD_W-1:0]   hold_cnt_q [CHANNELS];
   logic [HOLD_W-1:0]   hold_cnt_d [CHANNELS];
   logic [CHANNELS-1:0] hold_q, hold_d;

   // Counter restarts from zero on every new high period; hold drops with stable_out.
   always_comb begin
      hold_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         hold_cnt_d[i] = '0;
         if (stable_d[i] && stable_q[i]) begin
            hold_cnt_d[i] = (hold_cnt_q[i] == HOLD_LAST) ? hold_cnt_q[i]
                                                         : hold_cnt_q[i] + 1'b1;
         end
         hold_d[i] = stable_d[i] && (hold_cnt_d[i] == HOLD_LAST);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            hold_cnt_q[i] <= '0;
         end
      end else begin
         hold_q <= hold_d;
         for (int i = 0; i < CHANNELS; i++) begin
            hold_cnt_q[i] <= hold_cnt_d[i];
         end
      end
   end

   assign hold = hold_q;
`else
   assign hold = {CHANNELS{1'b0}} & {CHANNELS{HOLD_CYCLES > 0}};
`endif

endmodule

// File: tb/tb_irrigation_input_conditioner.sv
// Bench for irrigation_input_conditioner: pulse events are scoreboarded, levels are checked against fixed timelines.
module tb_irrigation_input_conditioner;

`ifdef IRRIGATION_HOLD_DETECT_EN
   localparam int HOLD_EN = 1;
`else
   localparam int HOLD_EN = 0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] raw_in = 3'b000;
   logic [2:0] stable_out, rise_pulse, fall_pulse, hold;
   logic       conflict, busy;

   irrigation_input_conditioner #(
      .CHANNELS(3), .DEBOUNCE_CYCLES(16), .CNT_W(5), .HOLD_CYCLES(64)
   ) dut (
      .clock(clock), .reset(reset), .raw_in(raw_in),
      .stable_out(stable_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .conflict(conflict), .busy(busy), .hold(hold)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at cyc %0d", tag, obs, exp, cyc);
      end
   endtask

   typedef struct {
      int ch;
      int rise;
      int at;
   } ev_t;

   ev_t exp_q[$];

   task automatic push_ev(input int ch, input int rise, input int at);
      ev_t e;
      e.ch = ch; e.rise = rise; e.at = at;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input int ch, input int rise);
      ev_t e;
      if (exp_q.size() == 0) begin
         check_eq("unexpected_pulse", 32'(ch), 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         check_eq("pulse_ch", 32'(ch), 32'(e.ch));
         check_eq("pulse_dir", 32'(rise), 32'(e.rise));
         check_eq("pulse_cyc", 32'(cyc), 32'(e.at));
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            if (rise_pulse[i]) pop_cmp(i, 1);
            if (fall_pulse[i]) pop_cmp(i, 0);
         end
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clock);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_stable"}, 32'(stable_out), 32'd0);
      check_eq({tag, "_pulses"}, 32'(rise_pulse | fall_pulse), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_conflict"}, 32'(conflict), 32'd0);
      check_eq({tag, "_hold"}, 32'(hold), 32'd0);
   endtask

   int e0, f0, g0, r0, d0, l0;
   int glitch_len [2] = '{10, 15};

   initial begin
      #1 reset = 1'b0;
      #1 check_all_zero("in_reset");
      repeat (3) @(negedge clock);
      reset = 1'b1;

      // idle
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         check_all_zero("idle");
      end

      // clean rise then fall on asp; spec cycle n = cyc - e0 - 1
      e0 = cyc;
      raw_in[0] = 1'b1;
      push_ev(0, 1, e0 + 19);
      for (int n = 0; n < 22; n++) begin
         wait_cyc(e0 + 1 + n);
         check_eq("rise_busy", 32'(busy), 32'((n >= 2 && n <= 17) ? 1 : 0));
         check_eq("rise_stable0", 32'(stable_out[0]), 32'((n >= 18) ? 1 : 0));
      end
      f0 = cyc;
      raw_in[0] = 1'b0;
      push_ev(0, 0, f0 + 19);
      wait_cyc(f0 + 18);
      check_eq("fall_pre_stable0", 32'(stable_out[0]), 32'd1);
      wait_cyc(f0 + 19);
      check_eq("fall_stable0", 32'(stable_out[0]), 32'd0);
      wait_cyc(f0 + 24);
      check_eq("fall_busy_idle", 32'(busy), 32'd0);

      // short glitches on adb must be ignored
      foreach (glitch_len[j]) begin
         e0 = cyc;
         raw_in[2] = 1'b1;
         wait_cyc(e0 + glitch_len[j]);
         raw_in[2] = 1'b0;
         for (int k = 1; k <= 40; k++) begin
            wait_cyc(e0 + k);
            check_eq("glitch_stable2", 32'(stable_out[2]), 32'd0);
         end
         check_eq("glitch_busy", 32'(busy), 32'd0);
      end

      // bouncing got: counter restarts on each bounce, qualifies after final edge
      raw_in[1] = 1'b1; repeat (5) @(negedge clock);
      raw_in[1] = 1'b0; repeat (3) @(negedge clock);
      raw_in[1] = 1'b1; repeat (8) @(negedge clock);
      raw_in[1] = 1'b0; repeat (2) @(negedge clock);
      l0 = cyc;
      raw_in[1] = 1'b1;
      push_ev(1, 1, l0 + 19);
      wait_cyc(l0 + 18);
      check_eq("bounce_pre_stable1", 32'(stable_out[1]), 32'd0);
      wait_cyc(l0 + 19);
      check_eq("bounce_stable1", 32'(stable_out[1]), 32'd1);
      wait_cyc(l0 + 22);
      f0 = cyc;
      raw_in[1] = 1'b0;
      push_ev(1, 0, f0 + 19);
      wait_cyc(f0 + 24);
      check_eq("bounce_conflict", 32'(conflict), 32'd0);

      // conflict: both requested together, then released one at a time
      e0 = cyc;
      raw_in[1:0] = 2'b11;
      push_ev(0, 1, e0 + 19);
      push_ev(1, 1, e0 + 19);
      wait_cyc(e0 + 19);
      check_eq("conf_pre", 32'(conflict), 32'd0);
      check_eq("conf_both_stable", 32'(stable_out), 32'd3);
      wait_cyc(e0 + 20);
      check_eq("conf_set", 32'(conflict), 32'd1);
      wait_cyc(e0 + 25);
      f0 = cyc;
      raw_in[0] = 1'b0;
      push_ev(0, 0, f0 + 19);
      for (int k = 1; k <= 25; k++) begin
         wait_cyc(f0 + k);
         check_eq("conf_held", 32'(conflict), 32'd1);
      end
      g0 = cyc;
      raw_in[1] = 1'b0;
      push_ev(1, 0, g0 + 19);
      wait_cyc(g0 + 19);
      check_eq("conf_last_cycle", 32'(conflict), 32'd1);
      check_eq("conf_stable1_low", 32'(stable_out[1]), 32'd0);
      wait_cyc(g0 + 20);
      check_eq("conf_clear", 32'(conflict), 32'd0);
      wait_cyc(g0 + 24);

      // reset in the middle of a PEND_HIGH on got, with asp already stable high
      e0 = cyc;
      raw_in[0] = 1'b1;
      push_ev(0, 1, e0 + 19);
      wait_cyc(e0 + 22);
      l0 = cyc;
      raw_in[1] = 1'b1;
      wait_cyc(l0 + 13);
      check_eq("rst_pre_busy", 32'(busy), 32'd1);
      check_eq("rst_pre_stable", 32'(stable_out), 32'd1);
      @(posedge clock);
      #2 reset = 1'b0;
      #1 check_all_zero("rst_async");
      repeat (3) @(negedge clock);
      r0 = cyc;
      reset = 1'b1;
      push_ev(0, 1, r0 + 19);
      push_ev(1, 1, r0 + 19);
      wait_cyc(r0 + 18);
      check_eq("rst_requal_pre", 32'(stable_out), 32'd0);
      wait_cyc(r0 + 19);
      check_eq("rst_requal", 32'(stable_out), 32'd3);
      wait_cyc(r0 + 20);
      check_eq("rst_conflict", 32'(conflict), 32'd1);

      // long press on asp and got
      wait_cyc(r0 + 82);
      check_eq("hold_pre", 32'(hold), 32'd0);
      wait_cyc(r0 + 83);
      check_eq("hold_set", 32'(hold), HOLD_EN ? 32'd3 : 32'd0);
      wait_cyc(r0 + 90);
      d0 = cyc;
      raw_in[0] = 1'b0;
      push_ev(0, 0, d0 + 19);
      wait_cyc(d0 + 18);
      check_eq("hold_before_fall", 32'(hold), HOLD_EN ? 32'd3 : 32'd0);
      wait_cyc(d0 + 19);
      check_eq("hold_with_fall", 32'(hold), HOLD_EN ? 32'd2 : 32'd0);
      check_eq("hold_fall_pulse", 32'(fall_pulse), 32'd1);
      wait_cyc(d0 + 22);
      g0 = cyc;
      raw_in[1] = 1'b0;
      push_ev(1, 0, g0 + 19);
      wait_cyc(g0 + 19);
      check_eq("hold_cleared", 32'(hold), 32'd0);
      wait_cyc(g0 + 20);
      check_eq("end_conflict", 32'(conflict), 32'd0);

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clock);
      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge clock);
      check_all_zero("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
